// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) transmit encoder and LSB-first bit serializer with start/end-of-frame strobes.
// Latency: a nibble accepted on edge T drives ser_valid/ser_sof from the following cycle; a frame spans 7*BIT_CYCLES cycles.
// Backpressure: in_ready is high while idle and on the last cycle of bit 6 (gapless back-to-back frames); it never depends on in_valid.
// Optional feature: define HAM_ERR_INJECT_EN to flip codeword bit (err_inj_pos-1) on load.

module ham_encoder_tx #(
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] err_inj_pos,
  output logic [6:0] cw_data,
  output logic       ser_bit,
  output logic       ser_valid,
  output logic       ser_sof,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  // Reject out-of-range hold lengths at elaboration; the hold counter is 4 bits wide.
  if (BIT_CYCLES < 1 || BIT_CYCLES > 16) begin : g_bad_bit_cycles
    $error("ham_encoder_tx: BIT_CYCLES must be in 1..16");
  end

  localparam logic [3:0] HOLD_LAST = 4'(BIT_CYCLES - 1);
  localparam logic [2:0] BIT_LAST  = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] cw_q;
  logic [6:0] cw_load;
  logic [2:0] bit_idx;
  logic [3:0] hold_cnt;
  logic [7:0] frame_cnt_q;
  logic       last_hold;
  logic       last_cycle;
  logic       xfer;

  // Codeword layout shared with the decoder: {d3,d2,d1,p4,d0,p2,p1}.
  function automatic logic [6:0] ham_encode(input logic [3:0] d);
    logic p1;
    logic p2;
    logic p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  assign last_hold  = (hold_cnt == HOLD_LAST);
  assign last_cycle = (state == SHIFT) && (bit_idx == BIT_LAST) && last_hold;

  // Ready comes from registered state only, so there is no in_valid -> in_ready path.
  assign in_ready = (state == IDLE) || last_cycle;
  assign xfer     = in_valid && in_ready;

`ifdef HAM_ERR_INJECT_EN
  // Word to load on a transfer: clean encoding with one optional bit flipped for decoder testing.
  always_comb begin
    cw_load = ham_encode(in_data);
    if (err_inj_pos != 3'd0) begin
      cw_load = cw_load ^ (7'd1 << (err_inj_pos - 3'd1));
    end
  end
`else
  logic unused_err_inj;
  assign unused_err_inj = ^err_inj_pos;

  // Word to load on a transfer: always the clean encoding.
  always_comb begin
    cw_load = ham_encode(in_data);
  end
`endif

  // Next-state logic: a transfer starts a frame; the final cycle either chains or returns idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_cycle) begin
          state_nxt = xfer ? SHIFT : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Codeword register, loaded only on a transfer and held for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_q <= '0;
    end else if (xfer) begin
      cw_q <= cw_load;
    end
  end

  // Bit position and per-bit hold counter; a transfer always restarts at bit 0, hold 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= '0;
      hold_cnt <= '0;
    end else if (xfer) begin
      bit_idx  <= '0;
      hold_cnt <= '0;
    end else if (state == SHIFT) begin
      if (last_hold) begin
        hold_cnt <= '0;
        bit_idx  <= (bit_idx == BIT_LAST) ? 3'd0 : bit_idx + 3'd1;
      end else begin
        hold_cnt <= hold_cnt + 4'd1;
      end
    end
  end

  // Completed-frame counter, free-running modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (last_cycle) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign cw_data    = cw_q;
  assign frame_cnt  = frame_cnt_q;
  assign ser_valid  = (state == SHIFT);
  assign ser_bit    = (state == SHIFT) && cw_q[bit_idx];
  assign ser_sof    = (state == SHIFT) && (bit_idx == 3'd0) && (hold_cnt == 4'd0);
  assign frame_done = last_cycle;

endmodule

// File: tb/tb_ham_encoder_tx.sv
// Scoreboarded bench for ham_encoder_tx: two instances (BIT_CYCLES 1 and 3) driven by directed and random nibbles.
// Expected codewords come from spec constants or a position-based Hamming model and are queued at transfer time.
// A negedge monitor pops and checks every serial cycle, the strobes, in_ready, frame_cnt and reset values.

module tb_ham_encoder_tx;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data    [N];
  logic       in_valid   [N];
  logic       in_ready   [N];
  logic [2:0] err_pos    [N];
  logic [6:0] cw_data    [N];
  logic       ser_bit    [N];
  logic       ser_valid  [N];
  logic       ser_sof    [N];
  logic       frame_done [N];
  logic [7:0] frame_cnt  [N];

  always #5 clk = ~clk;

  ham_encoder_tx #(.BIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .err_inj_pos(err_pos[0]), .cw_data(cw_data[0]),
    .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]), .ser_sof(ser_sof[0]),
    .frame_done(frame_done[0]), .frame_cnt(frame_cnt[0])
  );

  ham_encoder_tx #(.BIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .err_inj_pos(err_pos[1]), .cw_data(cw_data[1]),
    .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]), .ser_sof(ser_sof[1]),
    .frame_done(frame_done[1]), .frame_cnt(frame_cnt[1])
  );

  // Scoreboard and monitor state.
  logic [6:0] q0 [$];
  logic [6:0] q1 [$];
  logic [6:0] exp_next   [N];
  bit         xfer_seen  [N];
  bit         in_frame   [N];
  logic [6:0] cur        [N];
  int         k          [N];
  int         done_cnt   [N];
  int         done_total [N];
  int         xfer_total [N];
  int         aborted    [N];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         tmo_cnt  = 0;
  bit         end_chk  = 1'b0;
  bit         end_done = 1'b0;

  function automatic int bcyc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Reference Hamming(7,4): positions 1..7, data in non-power-of-two slots, parity p covers positions with bit p set.
  function automatic logic [6:0] ref_cw(input logic [3:0] d, input logic [2:0] e);
    logic [7:0] w;
    int di;
    w = '0;
    di = 0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[di];
        di++;
      end
    end
    for (int p = 1; p <= 4; p = p * 2) begin
      for (int q = p + 1; q <= 7; q++) begin
        if ((q & p) != 0) w[p] = w[p] ^ w[q];
      end
    end
`ifdef HAM_ERR_INJECT_EN
    if (e != 3'd0) w[e] = ~w[e];
`else
    if (e == 3'd0) w[0] = 1'b0;
`endif
    return w[7:1];
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
  endtask

  // Record transfers at the sampling edge and queue the expected codeword issued by the driver.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        xfer_seen[i] = 1'b0;
      end else begin
        xfer_seen[i] = in_valid[i] && in_ready[i];
        if (xfer_seen[i]) begin
          if (i == 0) q0.push_back(exp_next[i]);
          else q1.push_back(exp_next[i]);
          xfer_total[i]++;
        end
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the frame position the scoreboard expects.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int bc;
      int flen;
      int qs;
      bc = bcyc(i);
      flen = 7 * bc;
      if (!rst_n) begin
        chk("rst_in_ready", i, in_ready[i], 1);
        chk("rst_cw_data", i, cw_data[i], 0);
        chk("rst_ser_bit", i, ser_bit[i], 0);
        chk("rst_ser_valid", i, ser_valid[i], 0);
        chk("rst_ser_sof", i, ser_sof[i], 0);
        chk("rst_frame_done", i, frame_done[i], 0);
        chk("rst_frame_cnt", i, frame_cnt[i], 0);
        if (in_frame[i] || xfer_seen[i]) aborted[i]++;
        in_frame[i] = 1'b0;
        done_cnt[i] = 0;
        if (i == 0) q0.delete();
        else q1.delete();
      end else begin
        if (xfer_seen[i]) begin
          chk("xfer_outside_frame", i, in_frame[i], 0);
          qs = (i == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            chk("sb_nonempty", i, 0, 1);
          end else begin
            cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
          end
          k[i] = 0;
          in_frame[i] = 1'b1;
        end
        chk("ser_valid", i, ser_valid[i], in_frame[i]);
        chk("ser_sof", i, ser_sof[i], in_frame[i] && k[i] == 0);
        chk("frame_done", i, frame_done[i], in_frame[i] && k[i] == flen - 1);
        chk("in_ready", i, in_ready[i], !in_frame[i] || k[i] == flen - 1);
        chk("frame_cnt", i, frame_cnt[i], done_cnt[i]);
        if (in_frame[i]) begin
          chk("cw_data", i, cw_data[i], cur[i]);
          chk("ser_bit", i, ser_bit[i], cur[i][k[i] / bc]);
          if (k[i] == flen - 1) begin
            done_cnt[i] = (done_cnt[i] + 1) % 256;
            done_total[i]++;
            in_frame[i] = 1'b0;
          end else begin
            k[i]++;
          end
        end
      end
    end
    if (end_chk && !end_done) begin
      for (int i = 0; i < N; i++) begin
        chk("frames_accounted", i, done_total[i] + aborted[i], xfer_total[i]);
        chk("sb_drained", i, (i == 0) ? q0.size() : q1.size(), 0);
        chk("idle_at_end", i, in_frame[i], 0);
      end
      chk("accept_timeouts", 0, tmo_cnt, 0);
      end_done = 1'b1;
    end
  end

  // Offer one nibble and wait (bounded) for acceptance; hold keeps in_valid high for a gapless next frame.
  task automatic send(input int i, input logic [3:0] d, input logic [2:0] e, input logic [6:0] exp, input bit hold);
    bit ok;
    in_data[i] = d;
    err_pos[i] = e;
    exp_next[i] = exp;
    in_valid[i] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk);
      ok = in_ready[i];
    end
    #1;
    if (!ok) tmo_cnt++;
    if (!hold || !ok) in_valid[i] = 1'b0;
  endtask

  task automatic rand_run(input int i, input int nfr);
    for (int f = 0; f < nfr; f++) begin
      logic [3:0] d;
      logic [2:0] e;
      int gap;
      d = 4'($urandom);
      e = 3'($urandom);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      send(i, d, e, ref_cw(d, e), (gap == 0) && (f < nfr - 1));
      repeat (gap) @(posedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_data[i] = '0;
      in_valid[i] = 1'b0;
      err_pos[i] = '0;
      exp_next[i] = '0;
      in_frame[i] = 1'b0;
      xfer_seen[i] = 1'b0;
      k[i] = 0;
      done_cnt[i] = 0;
      done_total[i] = 0;
      xfer_total[i] = 0;
      aborted[i] = 0;
      cur[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Known-answer encoding.
    send(0, 4'b1011, 3'd0, 7'b1010101, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // Back-to-back frames with in_valid held.
    send(0, 4'b0000, 3'd0, 7'b0000000, 1'b1);
    send(0, 4'b1111, 3'd0, 7'b1111111, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // Stretched bits.
    send(1, 4'b0001, 3'd0, 7'b0000111, 1'b0);
    repeat (25) @(posedge clk);
    #1;

    // Reset during bit 3, then a fresh frame.
    send(0, 4'b1011, 3'd0, 7'b1010101, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 4'b1011, 3'd0, 7'b1010101, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // Error injection request: applied only when the feature is built in.
`ifdef HAM_ERR_INJECT_EN
    send(0, 4'b1011, 3'd7, 7'b0010101, 1'b0);
    send(0, 4'b1011, 3'd0, 7'b1010101, 1'b0);
`else
    send(0, 4'b1011, 3'd7, 7'b1010101, 1'b0);
`endif
    repeat (10) @(posedge clk);
    #1;

    // Random traffic on both instances; dut0 runs well past a frame_cnt wrap.
    fork
      rand_run(0, 300);
      rand_run(1, 60);
    join

    repeat (30) @(posedge clk);
    #1 end_chk = 1'b1;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
